// File: rtl/simd_arb_pkg.sv
// Shared state encoding and sizing helpers for the simd_array kernel arbiter.
// Holds no logic, so it adds no latency and applies no backpressure.
package simd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_DONE
    } arb_state_e;

    localparam int LAT_W_DEFAULT = 16;
    localparam logic [LAT_W_DEFAULT-1:0] LAT_MAX = '1;

    // Index width for a requester count; a single requester still needs one bit.
    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/simd_array_kernel_arbiter_rr_picker.sv
// Rotating-priority encoder: first set request at or above ptr_i, wrapping.
// Purely combinational, so zero latency and no backpressure of its own.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          vld_o,
    output logic [IW-1:0] idx_o
);

    int            j;
    logic [IW-1:0] jj;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        j     = 0;
        jj    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            jj = IW'(j);
            if (req_i[jj]) begin
                vld_o = 1'b1;
                idx_o = jj;
            end
        end
    end

endmodule

// File: rtl/simd_array_kernel_arbiter.sv
// Round-robin share of one ap_ctrl_hs kernel; grant to k_ap_start is 1 cycle, all outputs registered.
// Requesters are held off by withholding req_ack until ap_ready; one job is in flight at a time.
module simd_array_kernel_arbiter
    import simd_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ARG_W   = 32,
    parameter int LAT_W   = LAT_W_DEFAULT
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst_n,
    input  logic [NUM_REQ-1:0]             req_start,
    input  logic [NUM_REQ*ARG_W-1:0]       req_arg,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic [NUM_REQ-1:0]             req_done,
    output logic [LAT_W-1:0]               done_latency,
    output logic                           k_ap_start,
    input  logic                           k_ap_ready,
    input  logic                           k_ap_done,
    input  logic                           k_ap_idle,
    output logic [ARG_W-1:0]               k_arg,
    output logic                           busy,
    output logic [grant_w(NUM_REQ)-1:0]    grant_id
);

    localparam int GW = grant_w(NUM_REQ);

    logic [1:0]          rst_sync_q;
    logic                rst_n_int;
    arb_state_e          state_q, state_d;
    logic                kstart_q, kstart_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                busy_q, busy_d;
    logic [ARG_W-1:0]    karg_q, karg_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [GW-1:0]       ptr_q, ptr_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [LAT_W-1:0]    cnt_q, cnt_d;
    logic [LAT_W-1:0]    cnt_inc;
    logic                pick_vld;
    logic [GW-1:0]       pick_idx;

    // Reset asserts immediately but releases two clocks later, aligned to ap_clk.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n_int = rst_sync_q[1];

    rr_picker #(
        .N  (NUM_REQ),
        .IW (GW)
    ) u_picker (
        .req_i (req_start),
        .ptr_i (ptr_q),
        .vld_o (pick_vld),
        .idx_o (pick_idx)
    );

    assign cnt_inc = (cnt_q == {LAT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        kstart_d = kstart_q;
        ack_d    = '0;
        done_d   = '0;
        karg_d   = karg_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        lat_d    = lat_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                kstart_d = 1'b0;
                if (pick_vld && k_ap_idle) begin
                    state_d  = ST_START;
                    kstart_d = 1'b1;
                    grant_d  = pick_idx;
                    karg_d   = req_arg[int'(pick_idx)*ARG_W +: ARG_W];
                    cnt_d    = LAT_W'(1);
                end
            end
            ST_START: begin
                cnt_d = cnt_inc;
                // ap_done without ap_ready is a kernel protocol error and is ignored.
                if (k_ap_ready) begin
                    kstart_d       = 1'b0;
                    ack_d[grant_q] = 1'b1;
                    if (k_ap_done) begin
                        state_d         = ST_DONE;
                        done_d[grant_q] = 1'b1;
                        lat_d           = cnt_q;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_inc;
                if (k_ap_done) begin
                    state_d         = ST_DONE;
                    done_d[grant_q] = 1'b1;
                    lat_d           = cnt_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ptr_d   = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge ap_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q  <= ST_IDLE;
            kstart_q <= 1'b0;
            ack_q    <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            karg_q   <= '0;
            grant_q  <= '0;
            ptr_q    <= '0;
            lat_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            kstart_q <= kstart_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            karg_q   <= karg_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            lat_q    <= lat_d;
            cnt_q    <= cnt_d;
        end
    end

    assign k_ap_start   = kstart_q;
    assign req_ack      = ack_q;
    assign req_done     = done_q;
    assign busy         = busy_q;
    assign k_arg        = karg_q;
    assign grant_id     = grant_q;
    assign done_latency = lat_q;

endmodule

// File: doc/simd_array_kernel_arbiter.md
Name: simd_array_kernel_arbiter

Overview:
Shares one ap_ctrl_hs simd_array kernel instance among NUM_REQ requesters. It arbitrates round-robin, latches the winner's argument, and drives the kernel start/ready/done handshake. It returns a per-requester accept pulse, a done pulse and a measured start-to-done latency. It sits between the requester logic and the kernel top, replacing the direct ap_start tie-off; kernel ap_continue remains tied high.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ARG_W, 32, width of the scalar/base-address argument passed to the kernel
LAT_W, 16, width of the latency counter (saturating)

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  asynchronous active-low reset
req_start  in  NUM_REQ  level request per requester; held until matching req_ack
req_arg  in  NUM_REQ*ARG_W  per-requester argument, slice i = requester i; stable while req_start[i]=1
req_ack  out  NUM_REQ  one-hot pulse: kernel accepted requester i's job (ap_ready seen)
req_done  out  NUM_REQ  one-hot pulse: requester i's job finished (ap_done seen)
done_latency  out  LAT_W  cycles from k_ap_start rise to k_ap_done, valid with any req_done bit
k_ap_start  out  1  kernel ap_start
k_ap_ready  in  1  kernel ap_ready
k_ap_done  in  1  kernel ap_done
k_ap_idle  in  1  kernel ap_idle (used only for the IDLE entry check)
k_arg  out  ARG_W  argument to kernel; held from grant until DONE
busy  out  1  high in every state except IDLE
grant_id  out  $clog2(NUM_REQ)  index of current/last granted requester

Behaviour:
- Reset (async assert, sync-released internally): state=IDLE; k_ap_start=0, req_ack=0, req_done=0, busy=0, k_arg=0, grant_id=0, done_latency=0, latency counter=0, RR pointer=0 (requester 0 highest priority first).
- All outputs are registered.
- FSM IDLE -> START -> RUN -> DONE -> IDLE.
- IDLE: if any req_start and k_ap_idle=1:
  - pick the first set bit searching from RR pointer upward, wrapping.
  - latch grant_id and k_arg=req_arg[grant].
  - next cycle enter START with k_ap_start=1, busy=1, counter=1.
  - With no request, stay in IDLE with all outputs idle.
- START: k_ap_start held high; counter increments each cycle.
  - On k_ap_ready=1: k_ap_start=0 next cycle and req_ack[grant] pulses one cycle.
  - If k_ap_done=1 in the same cycle as k_ap_ready, go straight to DONE; otherwise go to RUN.
- RUN: k_ap_start=0; counter increments, saturating at 2^LAT_W-1; wait for k_ap_done.
- DONE (1 cycle): req_done[grant]=1; done_latency=counter value including the ap_done cycle; RR pointer=grant+1 mod NUM_REQ; then IDLE.
  - Back-to-back jobs therefore cost 2 idle cycles of kernel start (DONE and IDLE).
- No overlap: a new job is never started before the previous ap_done (ap_ctrl_hs, non-pipelined invocation).
- k_ap_done while in IDLE or START without k_ap_ready is a protocol error: ignored, and no req_done is produced.
- Withdrawn request: req_start[i] dropping after grant does not abort the job; the job still completes and pulses ack/done.
- Requester re-assert: a requester may re-assert req_start the cycle after its req_ack; the new request is arbitrated only in the next IDLE.
- Reset mid-job: everything returns to reset values immediately, and no pending ack/done is emitted. The kernel itself must be reset by the same ap_rst_n.
- Latency example: ap_ready at start cycle 1 and ap_done 34 cycles after k_ap_start rise (33-deep pipeline + 1) gives done_latency=34.

Decomposition:
- Package simd_arb_pkg: state enum (ST_IDLE, ST_START, ST_RUN, ST_DONE), GRANT_W=$clog2(NUM_REQ) helper, LAT_MAX constant.
- One sub-module rr_picker: combinational rotate-priority encoder (req vector, pointer) -> (valid, index).
- The FSM, latches and counter stay in the top.

Test Plan:
- Single request: req_start=0001, req_arg[0]=0x1000, kernel ready after 1 cycle and done 34 cycles after start -> k_arg=0x1000, req_ack=0001 once, req_done=0001 once, done_latency=34, busy low 1 cycle after done.
- All four requesting continuously for 8 jobs -> grant order 0,1,2,3,0,1,2,3; each req_done one-hot; k_ap_start never high during RUN.
- k_ap_ready and k_ap_done asserted in the same cycle 2 cycles after start -> START goes directly to DONE; req_ack and req_done both fire for the same grant; done_latency=2.
- Kernel holds ap_ready low for 5 cycles -> k_ap_start stays high for exactly 6 cycles; req_ack fires once after ap_ready.
- ap_rst_n pulled low during RUN of requester 2 -> all outputs at reset values within the same cycle; after release with req_start=0100, requester 2 is granted and restarted from counter=1.
- Kernel done delayed 70000 cycles with LAT_W=16 -> done_latency=65535 (saturation); spurious k_ap_done in IDLE -> no req_done pulse.
